// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle MIPS core: sequences the core reset, counts RUN cycles and
// stops on halt request, PC stall or cycle budget. All outputs are registered.
module cpu_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 5,
  parameter int unsigned MAX_CYCLES   = 2048,
  parameter int unsigned STALL_LIMIT  = 4,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc,
  input  logic             halt_req,
  input  logic             restart,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned HoldW  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned StallW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;

  localparam logic [HoldW-1:0]  HoldLast = HoldW'(RESET_CYCLES - 1);
  localparam logic [StallW-1:0] StallMax = StallW'(STALL_LIMIT);
  localparam logic [CNT_W-1:0]  CntMax   = CNT_W'(MAX_CYCLES);

  localparam logic [1:0] CauseNone   = 2'b00;
  localparam logic [1:0] CauseBudget = 2'b01;
  localparam logic [1:0] CauseStall  = 2'b10;
  localparam logic [1:0] CauseHalt   = 2'b11;

  typedef enum logic [1:0] {StHold, StRun, StDone} state_e;

  state_e             state_q;
  logic [HoldW-1:0]   hold_cnt_q;
  logic [StallW-1:0]  stall_cnt_q;
  logic [PC_W-1:0]    pc_prev_q;
  logic               first_q;
  logic               cpu_reset_q;
  logic               running_q;
  logic               done_q;
  logic [1:0]         cause_q;
  logic [CNT_W-1:0]   cycle_cnt_q;

  logic [CNT_W-1:0]   cnt_inc;
  logic [StallW-1:0]  stall_inc;
  logic               hit_halt;
  logic               hit_stall;
  logic               hit_budget;

  // Exit conditions use the post-increment counter values of the current RUN cycle.
  always_comb begin
    cnt_inc    = cycle_cnt_q + CNT_W'(1);
    stall_inc  = '0;
    if (!first_q && (pc == pc_prev_q)) begin
      stall_inc = stall_cnt_q + StallW'(1);
    end
    hit_halt   = halt_req;
    hit_stall  = (STALL_LIMIT != 0) && (stall_inc == StallMax);
    hit_budget = (MAX_CYCLES != 0) && (cnt_inc == CntMax);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      stall_cnt_q <= '0;
      pc_prev_q   <= '0;
      first_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      cause_q     <= CauseNone;
      cycle_cnt_q <= '0;
    end else begin
      case (state_q)
        StHold: begin
          if (hold_cnt_q == HoldLast) begin
            state_q     <= StRun;
            cpu_reset_q <= 1'b0;
            running_q   <= 1'b1;
            pc_prev_q   <= pc;
            first_q     <= 1'b1;
            stall_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HoldW'(1);
          end
        end
        StRun: begin
          cycle_cnt_q <= cnt_inc;
          pc_prev_q   <= pc;
          stall_cnt_q <= stall_inc;
          first_q     <= 1'b0;
          if (hit_halt || hit_stall || hit_budget) begin
            state_q     <= StDone;
            running_q   <= 1'b0;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b1;
            if (hit_halt) begin
              cause_q <= CauseHalt;
            end else if (hit_stall) begin
              cause_q <= CauseStall;
            end else begin
              cause_q <= CauseBudget;
            end
          end
        end
        StDone: begin
          // Core stays in reset; counters and cause hold until restart.
          if (restart) begin
            state_q     <= StHold;
            hold_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            cause_q     <= CauseNone;
            done_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= StHold;
        end
      endcase
    end
  end

  assign cpu_reset = cpu_reset_q;
  assign running   = running_q;
  assign done      = done_q;
  assign cause     = cause_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: four instances cover reset sequencing, budget, stall,
// simultaneous exit, restart, mid-run reset and counter wrap.
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [4];
  logic [31:0] pc    [4];
  logic        halt  [4];
  logic        rsrt  [4];
  logic        cpurst[4];
  logic        run   [4];
  logic        dn    [4];
  logic [1:0]  cse   [4];
  logic [31:0] cnt   [3];
  logic [3:0]  cnt_w;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_run_ctrl #(.RESET_CYCLES(5), .MAX_CYCLES(16), .STALL_LIMIT(0)) u_budget (
    .clk(clk), .reset(rst[0]), .pc(pc[0]), .halt_req(halt[0]), .restart(rsrt[0]),
    .cpu_reset(cpurst[0]), .running(run[0]), .done(dn[0]), .cause(cse[0]), .cycle_cnt(cnt[0])
  );

  cpu_run_ctrl #(.RESET_CYCLES(5), .MAX_CYCLES(2048), .STALL_LIMIT(4)) u_stall (
    .clk(clk), .reset(rst[1]), .pc(pc[1]), .halt_req(halt[1]), .restart(rsrt[1]),
    .cpu_reset(cpurst[1]), .running(run[1]), .done(dn[1]), .cause(cse[1]), .cycle_cnt(cnt[1])
  );

  cpu_run_ctrl #(.RESET_CYCLES(5), .MAX_CYCLES(8), .STALL_LIMIT(0)) u_simul (
    .clk(clk), .reset(rst[2]), .pc(pc[2]), .halt_req(halt[2]), .restart(rsrt[2]),
    .cpu_reset(cpurst[2]), .running(run[2]), .done(dn[2]), .cause(cse[2]), .cycle_cnt(cnt[2])
  );

  cpu_run_ctrl #(.RESET_CYCLES(5), .MAX_CYCLES(0), .STALL_LIMIT(0), .CNT_W(4)) u_wrap (
    .clk(clk), .reset(rst[3]), .pc(pc[3]), .halt_req(halt[3]), .restart(rsrt[3]),
    .cpu_reset(cpurst[3]), .running(run[3]), .done(dn[3]), .cause(cse[3]), .cycle_cnt(cnt_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse, release, then the five hold edges; instance is in RUN afterwards.
  task automatic bring_up(input int k);
    rst[k] = 1'b1;
    step();
    step();
    rst[k] = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; pc[k] = 32'h0; halt[k] = 1'b0; rsrt[k] = 1'b0;
    end

    // Reset state and reset release sequencing.
    repeat (3) step();
    check_eq("rst_cpu_reset", 32'(cpurst[0]), 32'd1);
    check_eq("rst_running",   32'(run[0]),    32'd0);
    check_eq("rst_done",      32'(dn[0]),     32'd0);
    check_eq("rst_cause",     32'(cse[0]),    32'd0);
    check_eq("rst_cnt",       cnt[0],         32'd0);
    rst[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("hold_cpu_reset", 32'(cpurst[0]), 32'd1);
    end
    step();
    check_eq("run_cpu_reset", 32'(cpurst[0]), 32'd0);
    check_eq("run_running",   32'(run[0]),    32'd1);
    check_eq("run_cnt0",      cnt[0],         32'd0);

    // Budget run with a restart pulse in RUN that must be ignored.
    for (int i = 1; i <= 15; i++) begin
      pc[0] = pc[0] + 32'd4;
      rsrt[0] = (i == 5);
      step();
      if (i == 5 || i == 15) begin
        check_eq("budget_cnt",     cnt[0],      32'(i));
        check_eq("budget_running", 32'(run[0]), 32'd1);
        check_eq("budget_nodone",  32'(dn[0]),  32'd0);
      end
    end
    rsrt[0] = 1'b0;
    pc[0] = pc[0] + 32'd4;
    step();
    check_eq("budget_done",  32'(dn[0]),     32'd1);
    check_eq("budget_cause", 32'(cse[0]),    32'd1);
    check_eq("budget_cnt16", cnt[0],         32'd16);
    check_eq("budget_cpurst", 32'(cpurst[0]), 32'd1);
    check_eq("budget_norun", 32'(run[0]),    32'd0);
    for (int i = 0; i < 10; i++) begin
      pc[0] = pc[0] + 32'd4;
      step();
    end
    check_eq("budget_hold_done", 32'(dn[0]),  32'd1);
    check_eq("budget_hold_cnt",  cnt[0],      32'd16);
    check_eq("budget_hold_cse",  32'(cse[0]), 32'd1);

    // Restart from DONE.
    rsrt[0] = 1'b1;
    step();
    rsrt[0] = 1'b0;
    check_eq("restart_done",  32'(dn[0]),     32'd0);
    check_eq("restart_cause", 32'(cse[0]),    32'd0);
    check_eq("restart_cnt",   cnt[0],         32'd0);
    check_eq("restart_cpurst", 32'(cpurst[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("restart_hold", 32'(cpurst[0]), 32'd1);
    end
    step();
    check_eq("restart_run",    32'(run[0]),    32'd1);
    check_eq("restart_cpulow", 32'(cpurst[0]), 32'd0);

    // Stall: 0x3000, 0x3004, then stuck at 0x3008.
    pc[1] = 32'h3000;
    bring_up(1);
    check_eq("stall_running", 32'(run[1]), 32'd1);
    step();
    pc[1] = 32'h3004;
    step();
    pc[1] = 32'h3008;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("stall_nodone", 32'(dn[1]), 32'd0);
    end
    step();
    check_eq("stall_done",  32'(dn[1]),  32'd1);
    check_eq("stall_cause", 32'(cse[1]), 32'd2);
    check_eq("stall_cnt",   cnt[1],      32'd7);

    // Reset mid-run at cycle_cnt=100.
    rsrt[1] = 1'b1;
    step();
    rsrt[1] = 1'b0;
    repeat (5) step();
    for (int i = 0; i < 100; i++) begin
      pc[1] = pc[1] + 32'd4;
      step();
    end
    check_eq("mid_cnt100", cnt[1], 32'd100);
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    check_eq("mid_cnt0",    cnt[1],         32'd0);
    check_eq("mid_cpurst",  32'(cpurst[1]), 32'd1);
    check_eq("mid_done",    32'(dn[1]),     32'd0);
    check_eq("mid_running", 32'(run[1]),    32'd0);

    // Halt request on the budget edge wins.
    bring_up(2);
    for (int i = 0; i < 7; i++) begin
      pc[2] = pc[2] + 32'd4;
      step();
    end
    check_eq("simul_pre", 32'(dn[2]), 32'd0);
    halt[2] = 1'b1;
    pc[2] = pc[2] + 32'd4;
    step();
    halt[2] = 1'b0;
    check_eq("simul_done",  32'(dn[2]),  32'd1);
    check_eq("simul_cause", 32'(cse[2]), 32'd3);
    check_eq("simul_cnt",   cnt[2],      32'd8);

    // 4-bit counter wraps with the budget disabled.
    bring_up(3);
    for (int i = 0; i < 15; i++) begin
      pc[3] = pc[3] + 32'd4;
      step();
    end
    check_eq("wrap_15", 32'(cnt_w), 32'd15);
    pc[3] = pc[3] + 32'd4;
    step();
    check_eq("wrap_0",       32'(cnt_w),  32'd0);
    check_eq("wrap_nodone",  32'(dn[3]),  32'd0);
    check_eq("wrap_running", 32'(run[3]), 32'd1);
    repeat (3) begin
      pc[3] = pc[3] + 32'd4;
      step();
    end
    check_eq("wrap_3", 32'(cnt_w), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
